// File: rtl/bp_common_pkg.sv
// Shared types for the BlackParrot handshake checking collateral.
package bp_common_pkg;

  // Error codes reported by the handshake monitor
  typedef enum logic [1:0] {
    e_hs_none     = 2'd0,
    e_hs_drop     = 2'd1,
    e_hs_unstable = 2'd2,
    e_hs_timeout  = 2'd3
  } bp_hs_err_e;

  // Index width for n items, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_nonsynth_hs_chan.sv
// One ready/valid channel checker: tracks a stalled transfer, flags
// protocol errors combinationally in the violating cycle and counts
// completed handshakes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// st_idle  | no transfer outstanding
// st_wait  | valid seen without ready; payload captured, stall counting
module bp_nonsynth_hs_chan
  import bp_common_pkg::*;
#(
  parameter int width_p       = 64,
  parameter int timeout_p     = 1024,
  parameter int count_width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic                     v_i,
  input  logic                     ready_and_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     err_drop_o,
  output logic                     err_unstable_o,
  output logic                     err_timeout_o,
  output logic [count_width_p-1:0] txn_count_o
);

  localparam int stall_w_lp = $clog2(timeout_p + 1);
  localparam logic [stall_w_lp-1:0] stall_max_lp = stall_w_lp'(timeout_p);

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_wait = 1'b1;

  logic [0:0]               state_q, state_n;
  logic [width_p-1:0]       data_q, data_n;
  logic [stall_w_lp-1:0]    stall_q, stall_n;
  logic [count_width_p-1:0] cnt_q;
  logic                     hs;

  // Next-state, payload capture, stall count and error detection
  always_comb begin
    state_n        = state_q;
    data_n         = data_q;
    stall_n        = stall_q;
    hs             = 1'b0;
    err_drop_o     = 1'b0;
    err_unstable_o = 1'b0;
    err_timeout_o  = 1'b0;
    if (en_i) begin
      case (state_q)
        st_idle: begin
          if (v_i && ready_and_i) begin
            hs = 1'b1;
          end else if (v_i) begin
            state_n = st_wait;
            data_n  = data_i;
            stall_n = stall_w_lp'(1);
          end
        end
        default: begin
          if (!v_i) begin
            err_drop_o = 1'b1;
            state_n    = st_idle;
            stall_n    = '0;
          end else begin
            if (data_i != data_q) begin
              err_unstable_o = 1'b1;
              data_n         = data_i;
            end
            if (ready_and_i) begin
              hs      = 1'b1;
              state_n = st_idle;
              stall_n = '0;
            end else if (stall_q != stall_max_lp) begin
              stall_n = stall_q + stall_w_lp'(1);
            end
          end
        end
      endcase
      // Fires only on the cycle the count first lands on the limit; the
      // counter then saturates so the flag cannot repeat for this transfer.
      err_timeout_o = (stall_n == stall_max_lp) && (stall_q != stall_max_lp);
    end else begin
      state_n = st_idle;
      stall_n = '0;
    end
  end

  // FSM, captured payload and stall counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= st_idle;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      stall_q <= stall_n;
    end
  end

  // Saturating handshake counter; clear wins over a same-cycle handshake
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (hs && (cnt_q != '1)) begin
      cnt_q <= cnt_q + count_width_p'(1);
    end
  end

  assign txn_count_o = cnt_q;

endmodule

// File: rtl/bp_nonsynth_hs_monitor.sv
// Multi-channel ready/valid protocol monitor. Each channel is checked by
// its own bp_nonsynth_hs_chan; this level picks the first error to latch
// (lowest channel, unstable over timeout) and reports every error.
module bp_nonsynth_hs_monitor
  import bp_common_pkg::*;
#(
  parameter int num_ch_p        = 4,
  parameter int width_p         = 64,
  parameter int timeout_p       = 1024,
  parameter int count_width_p   = 32,
  parameter bit halt_on_error_p = 1'b0,
  // Clear to silence per-error messages, e.g. when errors are injected on purpose
  parameter bit print_errors_p  = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              en_i,
  input  logic                              clear_i,
  input  logic [num_ch_p-1:0]               v_i,
  input  logic [num_ch_p-1:0]               ready_and_i,
  input  logic [num_ch_p*width_p-1:0]       data_i,
  output logic                              error_o,
  output logic [clog2_min1(num_ch_p)-1:0]   error_ch_o,
  output logic [1:0]                        error_code_o,
  output logic [num_ch_p*count_width_p-1:0] txn_count_o
);

  localparam int ch_w_lp = clog2_min1(num_ch_p);

  if (num_ch_p < 1) begin : g_bad_num_ch
    $fatal(1, "bp_nonsynth_hs_monitor: num_ch_p must be >= 1");
  end
  if (timeout_p < 1) begin : g_bad_timeout
    $fatal(1, "bp_nonsynth_hs_monitor: timeout_p must be >= 1");
  end

  logic [num_ch_p-1:0] err_drop, err_unst, err_tmo;

  for (genvar k = 0; k < num_ch_p; k++) begin : g_ch
    bp_nonsynth_hs_chan #(
      .width_p      (width_p),
      .timeout_p    (timeout_p),
      .count_width_p(count_width_p)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .en_i          (en_i),
      .clear_i       (clear_i),
      .v_i           (v_i[k]),
      .ready_and_i   (ready_and_i[k]),
      .data_i        (data_i[k*width_p +: width_p]),
      .err_drop_o    (err_drop[k]),
      .err_unstable_o(err_unst[k]),
      .err_timeout_o (err_tmo[k]),
      .txn_count_o   (txn_count_o[k*count_width_p +: count_width_p])
    );
  end

  logic               any_err;
  logic [ch_w_lp-1:0] sel_ch;
  bp_hs_err_e         sel_code;

  // Pick the lowest erroring channel; scanning downward lets it overwrite
  always_comb begin
    any_err  = 1'b0;
    sel_ch   = '0;
    sel_code = e_hs_none;
    for (int k = num_ch_p - 1; k >= 0; k--) begin
      if (err_drop[k] || err_unst[k] || err_tmo[k]) begin
        any_err = 1'b1;
        sel_ch  = ch_w_lp'(k);
        if (err_unst[k])      sel_code = e_hs_unstable;
        else if (err_tmo[k])  sel_code = e_hs_timeout;
        else                  sel_code = e_hs_drop;
      end
    end
  end

  logic               error_q;
  logic [ch_w_lp-1:0] error_ch_q;
  bp_hs_err_e         error_code_q;

  // Sticky first-error latch; clear overrides any same-cycle error
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_q      <= 1'b0;
      error_ch_q   <= '0;
      error_code_q <= e_hs_none;
    end else if (clear_i) begin
      error_q      <= 1'b0;
      error_ch_q   <= '0;
      error_code_q <= e_hs_none;
    end else if (!error_q && any_err) begin
      error_q      <= 1'b1;
      error_ch_q   <= sel_ch;
      error_code_q <= sel_code;
    end
  end

  assign error_o      = error_q;
  assign error_ch_o   = error_ch_q;
  assign error_code_o = error_code_q;

  logic [63:0] cycle_q;

  // Free-running cycle count used only to timestamp messages
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cycle_q <= '0;
    else            cycle_q <= cycle_q + 64'd1;
  end

  // Report every error, latched or not, and optionally halt on the first
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (print_errors_p) begin
        for (int k = 0; k < num_ch_p; k++) begin
          if (err_drop[k])
            $error("hs_monitor: cycle %0d ch %0d code 1 (valid dropped)", cycle_q, k);
          if (err_unst[k])
            $error("hs_monitor: cycle %0d ch %0d code 2 (payload unstable)", cycle_q, k);
          if (err_tmo[k])
            $error("hs_monitor: cycle %0d ch %0d code 3 (timeout)", cycle_q, k);
        end
      end
      if (halt_on_error_p && any_err)
        $fatal(1, "hs_monitor: halting on error at cycle %0d", cycle_q);
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_hs_monitor.sv
// Randomized + directed bench for bp_nonsynth_hs_monitor. Stimulus pushes
// reference-model expectations; a monitor pops one per clock and compares.
module tb_bp_nonsynth_hs_monitor;

  localparam int NC   = 4;
  localparam int W    = 8;
  localparam int TO   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [NC-1:0]    v = '0;
  logic [NC-1:0]    r = '0;
  logic [NC*W-1:0]  d = '0;
  logic             error;
  logic [1:0]       error_ch;
  logic [1:0]       error_code;
  logic [NC*CW-1:0] txn;

  bp_nonsynth_hs_monitor #(
    .num_ch_p       (NC),
    .width_p        (W),
    .timeout_p      (TO),
    .count_width_p  (CW),
    .halt_on_error_p(1'b0),
    .print_errors_p (1'b0)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .en_i        (en),
    .clear_i     (clr),
    .v_i         (v),
    .ready_and_i (r),
    .data_i      (d),
    .error_o     (error),
    .error_ch_o  (error_ch),
    .error_code_o(error_code),
    .txn_count_o (txn)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic             err;
    logic [1:0]       ch;
    logic [1:0]       code;
    logic [NC*CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: per-channel "transfer outstanding" view
  bit         m_pend [NC];
  logic [W-1:0] m_cap [NC];
  int         m_stall[NC];
  bit         m_fired[NC];
  int         m_cnt  [NC];
  bit         m_err;
  int         m_ch;
  int         m_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NC; k++) begin
      m_pend[k] = 0; m_cap[k] = '0; m_stall[k] = 0; m_fired[k] = 0; m_cnt[k] = 0;
    end
    m_err = 0; m_ch = 0; m_code = 0;
  endfunction

  function automatic void model_step();
    bit dr[NC];
    bit un[NC];
    bit tm[NC];
    logic [W-1:0] dk;
    for (int k = 0; k < NC; k++) begin
      dk = d[k*W +: W];
      dr[k] = 0; un[k] = 0; tm[k] = 0;
      if (!en) begin
        m_pend[k] = 0; m_stall[k] = 0; m_fired[k] = 0;
      end else if (!m_pend[k]) begin
        if (v[k] && r[k]) begin
          m_cnt[k] = (m_cnt[k] < CMAX) ? m_cnt[k] + 1 : CMAX;
        end else if (v[k]) begin
          m_pend[k] = 1; m_cap[k] = dk; m_stall[k] = 1;
          m_fired[k] = (TO <= 1); tm[k] = (TO <= 1);
        end
      end else if (!v[k]) begin
        dr[k] = 1; m_pend[k] = 0;
      end else begin
        if (dk != m_cap[k]) begin un[k] = 1; m_cap[k] = dk; end
        if (r[k]) begin
          m_cnt[k] = (m_cnt[k] < CMAX) ? m_cnt[k] + 1 : CMAX;
          m_pend[k] = 0;
        end else begin
          m_stall[k]++;
          if (m_stall[k] >= TO && !m_fired[k]) begin tm[k] = 1; m_fired[k] = 1; end
        end
      end
    end
    if (clr) begin
      m_err = 0; m_ch = 0; m_code = 0;
      for (int k = 0; k < NC; k++) m_cnt[k] = 0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (!m_err && (dr[k] || un[k] || tm[k])) begin
          m_err = 1; m_ch = k;
          m_code = un[k] ? 2 : (tm[k] ? 3 : 1);
        end
      end
    end
  endfunction

  // Apply current inputs for one clock; called and returns at a falling edge
  task automatic cycle();
    exp_t e;
    model_step();
    e.err  = m_err;
    e.ch   = 2'(m_ch);
    e.code = 2'(m_code);
    for (int k = 0; k < NC; k++) e.cnt[k*CW +: CW] = CW'(m_cnt[k]);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expectation per clock, sampled just after the rising edge
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sticky_err", 32'({error, error_ch, error_code}), 32'({e.err, e.ch, e.code}));
      check("txn_count", 32'(txn), 32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_ch;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_error", 32'(error), 32'd0);
    check("rst_ch", 32'(error_ch), 32'd0);
    check("rst_code", 32'(error_code), 32'd0);
    check("rst_txn", 32'(txn), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;

    // Ch0 stalls three cycles then completes with a stable payload
    d[0 +: W] = 8'hA5; v[0] = 1'b1;
    repeat (3) cycle();
    r[0] = 1'b1; cycle();
    v = '0; r = '0; cycle();
    check("ch0_stall_cnt", 32'(txn[CW-1:0]), 32'd1);
    check("ch0_stall_err", 32'(error), 32'd0);

    // Ch2 payload changes while stalled
    clr = 1'b1; cycle(); clr = 1'b0;
    d[2*W +: W] = 8'h01; v[2] = 1'b1; cycle();
    check("unst_pre", 32'(error), 32'd0);
    d[2*W +: W] = 8'h02; cycle();
    check("unst_err", 32'(error), 32'd1);
    check("unst_ch", 32'(error_ch), 32'd2);
    check("unst_code", 32'(error_code), 32'd2);
    // Drop together with clear: clear wins
    v[2] = 1'b0; clr = 1'b1; cycle(); clr = 1'b0;
    check("clear_over_err", 32'({error, error_ch, error_code}), 32'd0);

    // Ch1 stalls 20 cycles: timeout latched after the 8th stall cycle
    d[1*W +: W] = 8'h07; v[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == TO - 1) check("tmo_pre", 32'(error), 32'd0);
      if (i == TO) begin
        check("tmo_code", 32'(error_code), 32'd3);
        check("tmo_ch", 32'(error_ch), 32'd1);
      end
    end
    v[1] = 1'b0; clr = 1'b1; cycle(); clr = 1'b0;

    // Ch1 and ch3 drop valid in the same cycle
    v[1] = 1'b1; v[3] = 1'b1; cycle();
    v = '0; cycle();
    check("drop_ch", 32'(error_ch), 32'd1);
    check("drop_code", 32'(error_code), 32'd1);
    clr = 1'b1; cycle(); clr = 1'b0;

    // Five back-to-back handshakes saturate a 2-bit counter
    v[0] = 1'b1; r[0] = 1'b1;
    repeat (5) cycle();
    check("sat_cnt", 32'(txn[CW-1:0]), 32'(CMAX));
    clr = 1'b1; cycle(); clr = 1'b0;
    check("clear_over_hs", 32'(txn[CW-1:0]), 32'd0);
    v = '0; r = '0;

    // Disable mid-stall: no drop error
    v[0] = 1'b1; cycle();
    en = 1'b0; v[0] = 1'b0; cycle();
    check("en_off_err", 32'(error), 32'd0);
    en = 1'b1;

    // Reset pulse mid-stall
    v[2] = 1'b1; r[2] = 1'b1; cycle();
    v = '0; r = '0;
    v[0] = 1'b1; cycle(); cycle();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_txn", 32'(txn), 32'd0);
    check("mid_rst_err", 32'(error), 32'd0);
    @(negedge clk);
    @(negedge clk);
    v = '0;
    reset_n = 1'b1;
    repeat (3) cycle();
    check("post_rst_err", 32'(error), 32'd0);

    // Randomized segments, each with one channel driven into long stalls
    for (int s = 0; s < 8; s++) begin
      stall_ch = $urandom_range(0, NC - 1);
      for (int c = 0; c < 50; c++) begin
        en  = ($urandom_range(0, 19) != 0);
        clr = ($urandom_range(0, 29) == 0);
        for (int k = 0; k < NC; k++) begin
          if (k == stall_ch) begin
            v[k] = 1'b1;
            r[k] = ($urandom_range(0, 15) == 0);
          end else begin
            v[k] = ($urandom_range(0, 9) < 7);
            r[k] = ($urandom_range(0, 9) < 4);
          end
          if ($urandom_range(0, 9) == 0) d[k*W +: W] = W'($urandom_range(0, 3));
        end
        cycle();
      end
    end

    v = '0; r = '0; en = 1'b1; clr = 1'b0;
    cycle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_hs_monitor.md
BP_NONSYNTH_HS_MONITOR -- requirements
Module: bp_nonsynth_hs_monitor

Interface
REQ-001 Parameter num_ch_p, default 4: number of monitored ready/valid channels.
REQ-002 Parameter width_p, default 64: payload width per channel.
REQ-003 Parameter timeout_p, default 1024: consecutive stall cycles before a timeout error.
REQ-004 Parameter count_width_p, default 32: width of each per-channel transaction counter.
REQ-005 Parameter halt_on_error_p, default 0: when 1, $fatal on the first error; when 0, $error only.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset_n_i  input  1  asynchronous active-low reset.
REQ-009 en_i  input  1  checking enable.
REQ-010 clear_i  input  1  synchronous clear of counters and sticky error.
REQ-011 v_i  input  num_ch_p  per-channel valid.
REQ-012 ready_and_i  input  num_ch_p  per-channel ready.
REQ-013 data_i  input  num_ch_p*width_p  per-channel payload; channel k at bits [k*width_p +: width_p].
REQ-014 error_o  output  1  sticky: any error has been recorded.
REQ-015 error_ch_o  output  clog2(num_ch_p), min 1  channel of the first recorded error.
REQ-016 error_code_o  output  2  code of the first error: 0 none, 1 valid dropped, 2 payload unstable, 3 timeout.
REQ-017 txn_count_o  output  num_ch_p*count_width_p  per-channel completed handshake counts.

Function
REQ-018 Each channel SHALL run a two-state FSM: IDLE and WAIT.
REQ-019 IDLE -> WAIT when v_i=1 and ready_and_i=0. The payload is captured and the stall counter is set to 1.
REQ-020 In IDLE, v_i=1 with ready_and_i=1 SHALL count one transaction and stay in IDLE.
REQ-021 In WAIT, v_i=1 with ready_and_i=1 SHALL count one transaction and go to IDLE, with no stability error if the payload matches.
REQ-022 In WAIT, v_i=0 SHALL raise a dropped error (code 1) and go to IDLE.
REQ-023 In WAIT with v_i=1, data differing from the captured payload SHALL raise an unstable error (code 2).
  - The new payload is recaptured.
  - The FSM stays in WAIT, or goes to IDLE if ready_and_i=1; the transaction is still counted.
REQ-024 In WAIT, the stall counter increments each cycle with v_i=1 and ready_and_i=0.
  - When it reaches timeout_p, a timeout error (code 3) SHALL be raised once.
  - It is not raised again until the channel returns to IDLE; the counter saturates.
REQ-025 Transaction counters SHALL saturate at 2^count_width_p-1 and never wrap.
REQ-026 Error reporting latency is one cycle: error_o/error_ch_o/error_code_o update on the edge after the violating cycle.
REQ-027 Only the first error SHALL be latched in the sticky outputs.
  - Simultaneous errors on several channels: lowest channel index wins.
  - Simultaneous codes on one channel: unstable wins over timeout.
  - Every error SHALL print a $error with cycle count, channel and code, regardless of latching.
REQ-028 en_i=0 SHALL force all channels to IDLE, clear stall counters, and suppress errors and counting; counters and sticky error hold.
REQ-029 clear_i=1 SHALL zero all counters and the sticky error outputs, overriding any handshake or error in the same cycle; FSMs are unaffected.
REQ-030 With halt_on_error_p=1, the first error SHALL call $fatal after printing.

Reset
REQ-031 reset_n_i low SHALL, asynchronously, set all FSMs to IDLE and set stall counters, txn_count_o, error_o, error_ch_o and error_code_o to 0.
REQ-032 Deassertion mid-transfer SHALL start checking fresh from IDLE, with no error for the interrupted transfer.

Structure
REQ-033 The error-code enum bp_hs_err_e (e_hs_none, e_hs_drop, e_hs_unstable, e_hs_timeout) SHALL live in bp_common_pkg.
REQ-034 A per-channel sub-module bp_nonsynth_hs_chan SHALL be instantiated num_ch_p times; arbitration and sticky latch stay in the top.
REQ-035 The block is non-synthesizable verification collateral; static parameter checks (num_ch_p>=1, timeout_p>=1) SHALL $fatal at elaboration.

Verification
REQ-036 Ch0: v=1, ready=0 for 3 cycles, then ready=1, data constant 0xA5 -> txn_count[0]=1, error_o=0.
REQ-037 Ch2: v=1, ready=0, data 0x1 then 0x2 next cycle -> error_o=1, error_ch_o=2, error_code_o=2 one cycle later.
REQ-038 timeout_p=8, ch1 stalled 20 cycles -> exactly one timeout $error; error_code_o=3 after the 8th stall cycle.
REQ-039 Ch3 and ch1 drop valid in the same cycle -> error_ch_o=1, error_code_o=1; both errors printed.
REQ-040 count_width_p=2, 5 back-to-back handshakes on ch0 -> txn_count[0]=3; clear_i with a handshake -> 0.
REQ-041 reset_n_i pulsed low mid-WAIT -> outputs 0 immediately; no drop error after release.
